// File: rtl/conv_ctrl_db_if.sv
// Handshake and status bundle between the coefficient loader/stream source
// and the convolution controller.
interface conv_ctrl_db_if #(
  parameter int COEFF_W = 8,
  parameter int K       = 3
);
  localparam int N = K * K;

  logic                   coeff_load;
  logic                   coeff_valid;
  logic [COEFF_W-1:0]     coeff_in;
  logic                   coeff_ready;
  logic                   data_load;
  logic [N*COEFF_W-1:0]   filter;
  logic                   filter_valid;
  logic                   enable;
  logic                   data_write;
  logic                   load_done;
  logic                   load_abort;

  modport master (
    output coeff_load, coeff_valid, coeff_in, data_load,
    input  coeff_ready, filter, filter_valid, enable, data_write,
           load_done, load_abort
  );

  modport slave (
    input  coeff_load, coeff_valid, coeff_in, data_load,
    output coeff_ready, filter, filter_valid, enable, data_write,
           load_done, load_abort
  );
endinterface

// File: rtl/conv_ctrl_db.sv
// Double-buffered coefficient controller: a loader fills a shadow bank while
// the active bank drives the datapath; banks swap only when streaming pauses.
module conv_ctrl_db #(
  parameter int COEFF_W  = 8,
  parameter int K        = 3,
  parameter int PIPE_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  conv_ctrl_db_if.slave bus
);
  localparam int N     = K * K;
  localparam int NW    = N * COEFF_W;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_PEND} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [NW-1:0]       shadow, active;
  logic                filter_valid_q;
  logic                enable_p0;
  logic [PIPE_LAT-1:0] wr_pipe;
  logic                load_done_q, load_abort_q;
  logic                done_nxt, abort_nxt, swap;
  logic                xfer, last;

  assign xfer = (state == L_LOAD) && bus.coeff_valid;
  assign last = (idx == IDX_W'(N - 1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    swap      = 1'b0;
    case (state)
      L_IDLE: begin
        if (bus.coeff_load) begin
          state_nxt = L_LOAD;
          idx_nxt   = '0;
        end
      end
      L_LOAD: begin
        // A transfer on the same cycle coeff_load drops still counts.
        if (xfer && last) begin
          state_nxt = L_PEND;
          done_nxt  = 1'b1;
        end else begin
          if (xfer) idx_nxt = idx + 1'b1;
          if (!bus.coeff_load) begin
            state_nxt = L_IDLE;
            abort_nxt = 1'b1;
          end
        end
      end
      L_PEND: begin
        if (!bus.data_load) begin
          swap      = 1'b1;
          state_nxt = L_IDLE;
        end
      end
      default: state_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= L_IDLE;
      idx            <= '0;
      shadow         <= '0;
      active         <= '0;
      filter_valid_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_abort_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      load_done_q  <= done_nxt;
      load_abort_q <= abort_nxt;
      if (xfer) shadow[idx*COEFF_W +: COEFF_W] <= bus.coeff_in;
      if (swap) begin
        active         <= shadow;
        filter_valid_q <= 1'b1;
      end
    end
  end

  // Stage p0: enable register; write strobe follows PIPE_LAT stages later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_p0 <= 1'b0;
      wr_pipe   <= '0;
    end else begin
      enable_p0 <= bus.data_load && filter_valid_q;
      wr_pipe   <= PIPE_LAT'({wr_pipe, enable_p0});
    end
  end

  assign bus.coeff_ready  = (state == L_LOAD);
  assign bus.filter       = active;
  assign bus.filter_valid = filter_valid_q;
  assign bus.enable       = enable_p0;
  assign bus.data_write   = wr_pipe[PIPE_LAT-1];
  assign bus.load_done    = load_done_q;
  assign bus.load_abort   = load_abort_q;
endmodule

// File: doc/conv_ctrl_db.md
CONV_CTRL_DB -- requirements
Module: conv_ctrl_db

Interface
REQ-001 Parameter COEFF_W, default 8: coefficient width in bits (>=2).
REQ-002 Parameter K, default 3: kernel is K x K, so N = K*K coefficients per set (K>=2).
REQ-003 Parameter PIPE_LAT, default 4: datapath latency in cycles from enable to data_write (>=1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 coeff_load  input  1  high = coefficient load session in progress.
REQ-007 coeff_valid  input  1  coeff_in carries a coefficient this cycle.
REQ-008 coeff_in  input  COEFF_W  coefficient value.
REQ-009 coeff_ready  output  1  loader accepts a coefficient this cycle.
REQ-010 data_load  input  1  high = stream data through the convolution datapath.
REQ-011 filter  output  N*COEFF_W  active coefficient bank.
REQ-012 filter_valid  output  1  active bank holds a complete set.
REQ-013 enable  output  1  datapath enable.
REQ-014 data_write  output  1  output-write strobe.
REQ-015 load_done  output  1  one-cycle pulse when shadow bank completes.
REQ-016 load_abort  output  1  one-cycle pulse when a partial load is discarded.

Function
REQ-017 Two banks: active (drives filter) and shadow (written by loader); loading never disturbs filter.
REQ-018 Loader FSM states: L_IDLE, L_LOAD, L_PEND.
REQ-019 L_IDLE -> L_LOAD when coeff_load=1; write index cleared to 0.
REQ-020 In L_LOAD, coeff_ready=1 and coeff_load=1; a transfer occurs on a cycle with coeff_valid=1 and coeff_ready=1.
REQ-021 Transfer number i (0-based) writes shadow[i*COEFF_W +: COEFF_W]; index increments by 1.
REQ-022 Transfer with index N-1: load_done pulses the following cycle, FSM -> L_PEND, coeff_ready=0.
REQ-023 coeff_load falling in L_LOAD before N transfers: partial set discarded, load_abort pulses 1 cycle, FSM -> L_IDLE, active bank unchanged.
REQ-024 Transfer and coeff_load fall in the same cycle: that transfer counts; if it is transfer N-1, completion wins and no abort.
REQ-025 L_PEND: swap (shadow copied to active, filter_valid set to 1) on the first cycle with data_load=0, then -> L_IDLE.
REQ-026 If data_load=0 when the set completes, swap occurs on the cycle after load_done; filter updates at that edge.
REQ-027 coeff_ready=0 in L_IDLE and L_PEND; coeff_valid is ignored there.
REQ-028 enable = data_load AND filter_valid, registered (1-cycle latency from data_load).
REQ-029 data_write = enable delayed exactly PIPE_LAT cycles through a shift register; one data_write per enable cycle.
REQ-030 Deasserting data_load drains the pipeline: data_write continues for PIPE_LAT cycles after enable falls.
REQ-031 filter_valid, once set, stays 1 until reset; it never returns to 0 on abort.

Reset
REQ-032 rst=0 immediately sets: FSM=L_IDLE, index=0, both banks=0, filter=0, filter_valid=0, enable=0, data_write=0, delay line=0, coeff_ready=0, load_done=0, load_abort=0.
REQ-033 Reset mid-load or mid-stream discards all state; no pulse on load_done or load_abort.
REQ-034 After rst returns to 1, the FSM responds no earlier than the next rising edge.

Verification (K=3, COEFF_W=8, PIPE_LAT=4)
REQ-035 Load 01,03,07,0F,1F,3F,7F,FF,83 with data_load=0 -> load_done one cycle after the 9th transfer; next edge filter=83_FF_7F_3F_1F_0F_07_03_01 (hex, MSB first), filter_valid=1.
REQ-036 After REQ-035, data_load=1 for 5 cycles -> enable high 5 cycles starting 1 cycle later; data_write high 5 cycles starting 4 cycles after enable.
REQ-037 While streaming, load a second set (all 0x11) -> filter unchanged until data_load falls; swaps to all-0x11 on the first data_load=0 cycle.
REQ-038 Drop coeff_load after 5 transfers -> load_abort one pulse, filter unchanged; next full load succeeds from index 0.
REQ-039 data_load=1 before any complete load -> enable and data_write stay 0.
REQ-040 Assert rst=0 mid-load at transfer 4 and mid-stream -> all outputs 0 asynchronously, no pulses; reload after release succeeds.
